// File: rtl/cache_ctrl_if.sv
// Bus bundle between a CPU-side requester, the cache controller and the
// backing memory.
//   cpu_*      : request/response handshake (req held until ready pulse)
//   flush      : invalidate-all pulse
//   mem_*      : backing-memory strobes, address, write data, read data
//   hit_cnt/miss_cnt : saturating access statistics
// slave  = cache controller view, master = requester/memory model view.
interface cache_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        flush;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
        output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
               hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
        input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// one-word lines.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cache_ctrl_if.slave (CPU handshake, memory strobes, counters)
//
//   state  | meaning
//   IDLE   | waiting for a request; flush and hit lookup happen here
//   MEM_RD | read miss, mem_read held for MEM_LAT cycles, fill on last
//   MEM_WR | write-through, mem_write held for MEM_LAT cycles
//   RESP   | cpu_ready pulse, inputs ignored
module cache_ctrl #(
    parameter int LINES   = 16,
    parameter int MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 8 - IDX_W;
    localparam int TMR_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, RESP} state_t;

    state_t            state, state_nx;
    logic [TMR_W-1:0]  tmr, tmr_nx;
    logic [LINES-1:0]  valid, valid_nx;
    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [31:0]       data_mem [LINES];

    logic              mem_read_nx, mem_write_nx, cpu_ready_nx;
    logic [31:0]       cpu_rdata_nx, mem_addr_nx, mem_wdata_nx;
    logic [15:0]       hit_nx, miss_nx;

    logic              line_we, tag_we;
    logic [IDX_W-1:0]  line_idx;
    logic [31:0]       line_data;

    logic [IDX_W-1:0]  idx, act_idx;
    logic [TAG_W-1:0]  tag, act_tag;
    logic              hit;
    logic              unused_addr_bits;

    assign idx     = bus.cpu_addr[IDX_W-1:0];
    assign tag     = bus.cpu_addr[7:IDX_W];
    // mem_addr holds the in-flight address, so the fill does not depend on
    // the requester keeping cpu_addr stable.
    assign act_idx = bus.mem_addr[IDX_W-1:0];
    assign act_tag = bus.mem_addr[7:IDX_W];
    assign hit     = valid[idx] && (tag_mem[idx] == tag);
    assign unused_addr_bits = ^bus.cpu_addr[31:8];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_nx     = state;
        tmr_nx       = tmr;
        valid_nx     = valid;
        mem_read_nx  = 1'b0;
        mem_write_nx = 1'b0;
        cpu_ready_nx = 1'b0;
        cpu_rdata_nx = bus.cpu_rdata;
        mem_addr_nx  = bus.mem_addr;
        mem_wdata_nx = bus.mem_wdata;
        hit_nx       = bus.hit_cnt;
        miss_nx      = bus.miss_cnt;
        line_we      = 1'b0;
        tag_we       = 1'b0;
        line_idx     = idx;
        line_data    = bus.cpu_wdata;

        case (state)
            IDLE: begin
                if (bus.flush) begin
                    valid_nx = '0;
                end else if (bus.cpu_req) begin
                    tmr_nx = TMR_LOAD;
                    if (!bus.cpu_we) begin
                        if (hit) begin
                            cpu_rdata_nx = data_mem[idx];
                            cpu_ready_nx = 1'b1;
                            hit_nx       = sat_inc(bus.hit_cnt);
                            state_nx     = RESP;
                        end else begin
                            mem_read_nx  = 1'b1;
                            mem_addr_nx  = {24'b0, bus.cpu_addr[7:0]};
                            miss_nx      = sat_inc(bus.miss_cnt);
                            state_nx     = MEM_RD;
                        end
                    end else begin
                        mem_write_nx = 1'b1;
                        mem_addr_nx  = {24'b0, bus.cpu_addr[7:0]};
                        mem_wdata_nx = bus.cpu_wdata;
                        state_nx     = MEM_WR;
                        if (hit) begin
                            line_we = 1'b1;
                            hit_nx  = sat_inc(bus.hit_cnt);
                        end else begin
                            miss_nx = sat_inc(bus.miss_cnt);
                        end
                    end
                end
            end
            MEM_RD: begin
                if (tmr == '0) begin
                    line_we           = 1'b1;
                    tag_we            = 1'b1;
                    line_idx          = act_idx;
                    line_data         = bus.mem_rdata;
                    valid_nx[act_idx] = 1'b1;
                    cpu_rdata_nx      = bus.mem_rdata;
                    cpu_ready_nx      = 1'b1;
                    state_nx          = RESP;
                end else begin
                    mem_read_nx = 1'b1;
                    tmr_nx      = tmr - TMR_W'(1);
                end
            end
            MEM_WR: begin
                if (tmr == '0) begin
                    cpu_ready_nx = 1'b1;
                    state_nx     = RESP;
                end else begin
                    mem_write_nx = 1'b1;
                    tmr_nx       = tmr - TMR_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tmr           <= '0;
            valid         <= '0;
            bus.cpu_ready <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.hit_cnt   <= '0;
            bus.miss_cnt  <= '0;
        end else begin
            state         <= state_nx;
            tmr           <= tmr_nx;
            valid         <= valid_nx;
            bus.cpu_ready <= cpu_ready_nx;
            bus.cpu_rdata <= cpu_rdata_nx;
            bus.mem_read  <= mem_read_nx;
            bus.mem_write <= mem_write_nx;
            bus.mem_addr  <= mem_addr_nx;
            bus.mem_wdata <= mem_wdata_nx;
            bus.hit_cnt   <= hit_nx;
            bus.miss_cnt  <= miss_nx;
        end
    end

    // Data and tags are not reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (line_we) data_mem[line_idx] <= line_data;
        if (tag_we)  tag_mem[line_idx]  <= act_tag;
    end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter LINES, 16, number of one-word cache lines (power of 2, 2..64).
REQ-002 Parameter MEM_LAT, 2, cycles each backing-memory access is held (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cpu_req  input  1  request valid, held until cpu_ready seen.
REQ-006 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req high.
REQ-007 cpu_addr  input  32  word address; only bits [7:0] used, upper bits ignored.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 flush  input  1  invalidate-all pulse.
REQ-010 cpu_rdata  output  32  registered read data, valid while cpu_ready high.
REQ-011 cpu_ready  output  1  one-cycle completion pulse.
REQ-012 mem_read  output  1  registered read strobe to backing memory.
REQ-013 mem_write  output  1  registered write strobe to backing memory.
REQ-014 mem_addr  output  32  {24'b0, cpu_addr[7:0]} of active access.
REQ-015 mem_wdata  output  32  write data to memory.
REQ-016 mem_rdata  input  32  read data from memory, valid by last MEM_LAT cycle.
REQ-017 hit_cnt, miss_cnt  output  16 each  saturating access counters.

Function
REQ-018 Direct-mapped: index = cpu_addr[log2(LINES)-1:0], tag = cpu_addr[7:log2(LINES)]; per line store valid bit, tag, 32-bit data.
REQ-019 Hit = cpu_req & valid[index] & tag match, evaluated only in IDLE.
REQ-020 FSM states IDLE, MEM_RD, MEM_WR, RESP; reset state IDLE.
REQ-021 IDLE, flush=1: clear all valid bits that edge; any cpu_req that cycle ignored and serviced from IDLE next cycle (flush wins).
REQ-022 IDLE, read hit: cpu_rdata <= line data, go RESP; cpu_ready high the next cycle (latency 1); hit_cnt +1.
REQ-023 IDLE, read miss: go MEM_RD; mem_read=1, mem_addr set, for exactly MEM_LAT cycles; miss_cnt +1.
REQ-024 Final MEM_RD cycle: capture mem_rdata into line data and cpu_rdata, set valid and tag, go RESP (read-miss latency MEM_LAT+1).
REQ-025 IDLE, write (hit or miss): go MEM_WR; mem_write=1, mem_addr, mem_wdata=cpu_wdata for exactly MEM_LAT cycles; write-through.
REQ-026 Write hit: line data updated with cpu_wdata, hit_cnt +1; write miss: no allocate, line untouched, miss_cnt +1.
REQ-027 End of MEM_WR: go RESP (write latency MEM_LAT+1); cpu_rdata unchanged on writes.
REQ-028 RESP: cpu_ready=1 for one cycle, cpu_req and flush ignored, then IDLE; back-to-back request accepted in following IDLE cycle.
REQ-029 mem_read and mem_write never high together; both 0 outside MEM_RD/MEM_WR.
REQ-030 flush in MEM_RD/MEM_WR/RESP ignored; no pending flush retained.
REQ-031 Counters saturate at 16'hFFFF, no wrap.
REQ-032 Addresses differing only above bit 7 alias the same line and tag.

Reset
REQ-033 rst_n low asynchronously: state IDLE, all valid bits 0, cpu_ready, mem_read, mem_write 0, cpu_rdata, mem_addr, mem_wdata 0, counters 0.
REQ-034 Reset mid-MEM_RD/MEM_WR aborts: strobes drop immediately, no line update, no cpu_ready.
REQ-035 Line data and tag arrays need not be reset; valid bits gate all use.

Verification
REQ-036 Read 0x05 cold, mem_rdata=0xDEADBEEF, MEM_LAT=2 -> mem_read high 2 cycles, cpu_ready cycle 3 with 0xDEADBEEF, miss_cnt=1.
REQ-037 Repeat read 0x05 -> no mem_read, cpu_ready next cycle, 0xDEADBEEF, hit_cnt=1.
REQ-038 Write 0x05=0x12345678 then read 0x05 -> mem_write 2 cycles with addr 0x05, read hits returning 0x12345678; write 0x25 (same index, other tag) -> line unchanged, miss_cnt +1.
REQ-039 flush and cpu_req read 0x05 same cycle -> valid cleared, request then misses (mem_read issued).
REQ-040 rst_n low during 2nd MEM_RD cycle -> mem_read 0 immediately, no cpu_ready, next read 0x05 misses.
REQ-041 Force hit_cnt to 0xFFFF via repeated hits -> stays 0xFFFF on further hits.
